// File: rtl/simple_phase_ctrl.sv
// Five-phase instruction sequencer (fetch/decode/exec/mem/writeback) for the SIMPLE datapath.
// 5 cycles per instruction, plus 1 per memory wait cycle; stalls on mem_rdy, errors after TIMEOUT waits.
module simple_phase_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             resume,
  input  logic [15:0]      ir_in,
  input  logic             alu_hlt,
  input  logic             mem_rdy,
  output logic [2:0]       phase,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             opr_we,
  output logic             dr_we,
  output logic             flag_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             rf_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] ir;
  logic [15:0] wait_cnt;

  logic [1:0] op1;
  logic [2:0] op2;
  logic [3:0] op3;
  logic       is_ld, is_st, mem_op;
  logic       halt_op, halt_now;
  logic       flag_op, rf_op, branch_op;
  logic       timeout_hit;
  logic       unused_ir_bits;

  assign op1 = ir[15:14];
  assign op2 = ir[13:11];
  assign op3 = ir[7:4];
  assign unused_ir_bits = ^{ir[10:8], ir[3:0]};

  assign is_ld     = (op1 == 2'b00);
  assign is_st     = (op1 == 2'b01);
  assign mem_op    = is_ld | is_st;
  assign halt_op   = (op1 == 2'b11) && (op3 == 4'hF);
  assign halt_now  = halt_op | alu_hlt;
  assign flag_op   = ((op1 == 2'b11) && (op3 inside {[4'd0:4'd6], [4'd8:4'd11]})) ||
                     ((op1 == 2'b10) && (op2 inside {3'b001, 3'b010}));
  assign rf_op     = ((op1 == 2'b11) && (op3 inside {[4'd0:4'd4], 4'd6, [4'd8:4'd11]})) ||
                     is_ld ||
                     ((op1 == 2'b10) && (op2 inside {3'b000, 3'b001}));
  assign branch_op = (op1 == 2'b10) && op2[2];

  // Outputs decode the registered state; the memory-completion strobes and the
  // exec-phase updates are additionally qualified by mem_rdy / alu_hlt of this cycle.
  always_comb begin
    phase    = state;
    mem_req  = (state == S_P1) || ((state == S_P4) && mem_op);
    addr_sel = (state == S_P4) && mem_op;
    mem_we   = (state == S_P4) && is_st;
    ir_we    = (state == S_P1) && mem_rdy;
    pc_inc   = (state == S_P1) && mem_rdy;
    opr_we   = (state == S_P2);
    dr_we    = (state == S_P3) && !halt_now;
    flag_we  = (state == S_P3) && !halt_now && flag_op;
    mdr_we   = (state == S_P4) && is_ld && mem_rdy;
    rf_we    = (state == S_P5) && rf_op;
    rf_src   = (state == S_P5) && is_ld;
    pc_load  = (state == S_P5) && branch_op;
    halted   = (state == S_HALT);
    err      = (state == S_ERR);
  end

  // A ready memory beats the timeout on the cycle the count would reach the limit.
  assign timeout_hit = (TIMEOUT != 0) && mem_req && !mem_rdy &&
                       ((wait_cnt + 16'd1) == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir       <= 16'h0000;
      wait_cnt <= 16'd0;
      retired  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state    <= S_P1;
            wait_cnt <= 16'd0;
          end
        end
        S_P1: begin
          if (mem_rdy) begin
            ir       <= ir_in;
            state    <= S_P2;
            wait_cnt <= 16'd0;
          end else if (timeout_hit) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_P2: state <= S_P3;
        S_P3: begin
          wait_cnt <= 16'd0;
          state    <= halt_now ? S_HALT : S_P4;
        end
        S_P4: begin
          if (!mem_op || mem_rdy) begin
            state    <= S_P5;
            wait_cnt <= 16'd0;
          end else if (timeout_hit) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_P5: begin
          retired  <= retired + 1'b1;
          wait_cnt <= 16'd0;
          state    <= stop ? S_IDLE : S_P1;
        end
        S_HALT: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (resume) begin
            state    <= S_P1;
            wait_cnt <= 16'd0;
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_phase_ctrl.sv
// Bench for simple_phase_ctrl: directed instruction sequences checked against a spec-level model.
module tb_simple_phase_ctrl;
  localparam int TO = 4;

  logic        clk, rst_n, start, stop, resume, alu_hlt, mem_rdy;
  logic [15:0] ir_in;
  logic [2:0]  phase;
  logic        ir_we, pc_inc, pc_load, opr_we, dr_we, flag_we, mdr_we, rf_we, rf_src;
  logic        mem_req, mem_we, addr_sel, halted, err;
  logic [15:0] retired;

  simple_phase_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .resume(resume),
    .ir_in(ir_in), .alu_hlt(alu_hlt), .mem_rdy(mem_rdy), .phase(phase),
    .ir_we(ir_we), .pc_inc(pc_inc), .pc_load(pc_load), .opr_we(opr_we),
    .dr_we(dr_we), .flag_we(flag_we), .mdr_we(mdr_we), .rf_we(rf_we),
    .rf_src(rf_src), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .halted(halted), .err(err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit 13..0: ir_we pc_inc pc_load opr_we dr_we flag_we mdr_we rf_we rf_src mem_req mem_we addr_sel halted err
  wire [13:0] outs = {ir_we, pc_inc, pc_load, opr_we, dr_we, flag_we, mdr_we, rf_we,
                      rf_src, mem_req, mem_we, addr_sel, halted, err};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ph;
  logic [15:0] m_ir;
  int          m_wait;
  logic [15:0] m_ret;

  function automatic bit mem_instr(input logic [15:0] w);  return w[15] == 1'b0; endfunction
  function automatic bit halt_word(input logic [15:0] w);  return w[15:14] == 2'd3 && w[7:4] == 4'd15; endfunction
  function automatic bit branch_w(input logic [15:0] w);   return w[15:14] == 2'd2 && w[13:11] >= 3'd4; endfunction
  function automatic bit flags_w(input logic [15:0] w);
    int o3 = int'(w[7:4]);
    int o2 = int'(w[13:11]);
    return (w[15:14] == 2'd3 && o3 < 12 && o3 != 7) || (w[15:14] == 2'd2 && (o2 == 1 || o2 == 2));
  endfunction
  function automatic bit rfw_w(input logic [15:0] w);
    int o3 = int'(w[7:4]);
    int o2 = int'(w[13:11]);
    return (w[15:14] == 2'd3 && o3 < 12 && o3 != 5 && o3 != 7) || w[15:14] == 2'd0 ||
           (w[15:14] == 2'd2 && o2 < 2);
  endfunction

  function automatic bit gives_up();
    return TO != 0 && m_wait + 1 >= TO;
  endfunction

  function automatic int next_ph();
    case (m_ph)
      0: return (start && !stop) ? 1 : 0;
      1: return mem_rdy ? 2 : (gives_up() ? 7 : 1);
      2: return 3;
      3: return (halt_word(m_ir) || alu_hlt) ? 6 : 4;
      4: if (mem_instr(m_ir)) return mem_rdy ? 5 : (gives_up() ? 7 : 4);
         else return 5;
      5: return stop ? 0 : 1;
      6: return stop ? 0 : (resume ? 1 : 6);
      default: return 7;
    endcase
  endfunction

  function automatic int next_wait();
    bit waiting = (m_ph == 1) || (m_ph == 4 && mem_instr(m_ir));
    if (next_ph() != m_ph || !waiting) return 0;
    return m_wait + 1;
  endfunction

  function automatic logic [13:0] exp_outs();
    bit p1 = (m_ph == 1), p2 = (m_ph == 2), p3 = (m_ph == 3), p4 = (m_ph == 4), p5 = (m_ph == 5);
    bit stopping = halt_word(m_ir) || alu_hlt;
    bit ld = (m_ir[15:14] == 2'd0), st = (m_ir[15:14] == 2'd1);
    return {p1 && mem_rdy, p1 && mem_rdy, p5 && branch_w(m_ir), p2,
            p3 && !stopping, p3 && !stopping && flags_w(m_ir), p4 && ld && mem_rdy,
            p5 && rfw_w(m_ir), p5 && ld, p1 || (p4 && (ld || st)), p4 && st,
            p4 && (ld || st), m_ph == 6, m_ph == 7};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_ir <= 16'h0; m_wait <= 0; m_ret <= 16'h0;
    end else begin
      m_ph   <= next_ph();
      m_wait <= next_wait();
      if (m_ph == 1 && mem_rdy) m_ir <= ir_in;
      if (m_ph == 5) m_ret <= m_ret + 16'd1;
    end
  end

  always @(negedge clk) begin
    chk("model phase", 32'(phase), 32'(m_ph));
    chk("model strobes", 32'(outs), 32'(exp_outs()));
    chk("model retired", 32'(retired), 32'(m_ret));
  end

  // ---------------- directed sequences ----------------
  int          ph_v[$];
  bit          rdy_v[$];
  logic [13:0] rec_out[16];
  int          rec_ret[16];

  task automatic run_seq(input string nm, input logic [15:0] w, input bit stp);
    ir_in = w; stop = 1'b0; start = 1'b1; mem_rdy = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; stop = stp;
    foreach (ph_v[i]) begin
      mem_rdy = rdy_v[i];
      @(negedge clk);
      rec_out[i] = outs;
      rec_ret[i] = int'(retired);
      chk($sformatf("%s phase[%0d]", nm, i), 32'(phase), 32'(ph_v[i]));
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 40 && phase != 3'd0; k++) begin
      @(posedge clk); #1;
    end
    chk({nm, " reach idle"}, 32'(phase), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; resume = 1'b0;
    alu_hlt = 1'b0; mem_rdy = 1'b0; ir_in = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset phase", 32'(phase), 32'd0);
    chk("reset strobes", 32'(outs), 32'd0);
    chk("reset retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // IDLE ignores resume/mem_rdy, and start+stop keeps it idle
    resume = 1'b1; mem_rdy = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0; mem_rdy = 1'b0; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start+stop idle", 32'(phase), 32'd0);
    @(posedge clk); #1;

    // ADD back-to-back
    ph_v = '{1, 2, 3, 4, 5, 1}; rdy_v = '{1, 1, 1, 1, 1, 1};
    run_seq("add", 16'hC000, 1'b0);
    chk("add flag_we p3", 32'(rec_out[2][8]), 32'd1);
    chk("add flag_we p4", 32'(rec_out[3][8]), 32'd0);
    chk("add rf_we p5", 32'(rec_out[4][6]), 32'd1);
    chk("add retired before", 32'(rec_ret[4]), 32'd0);
    chk("add retired after", 32'(rec_ret[5]), 32'd1);
    stop = 1'b1; wait_idle("add"); stop = 1'b0;
    chk("add retired 2", 32'(retired), 32'd2);

    // LD with 3 wait cycles in P4
    ph_v = '{1, 2, 3, 4, 4, 4, 4, 5, 0}; rdy_v = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    run_seq("ld", 16'h0000, 1'b1);
    chk("ld mem strobes p4", 32'(rec_out[3][4:2]), 32'b101);
    chk("ld mdr_we waiting", 32'(rec_out[5][7]), 32'd0);
    chk("ld mdr_we rdy", 32'(rec_out[6][7]), 32'd1);
    chk("ld rf_src p5", 32'(rec_out[7][5]), 32'd1);
    chk("ld rf_we p5", 32'(rec_out[7][6]), 32'd1);
    chk("ld retired", 32'(retired), 32'd3);

    // Branch and CMP
    ph_v = '{1, 2, 3, 4, 5, 0}; rdy_v = '{1, 1, 1, 1, 1, 1};
    run_seq("br", 16'hA000, 1'b1);
    chk("br pc_load", 32'(rec_out[4][11]), 32'd1);
    chk("br rf_we", 32'(rec_out[4][6]), 32'd0);
    chk("br flag_we", 32'(rec_out[2][8]), 32'd0);
    chk("br p4 no mem", 32'(rec_out[3][4:2]), 32'd0);
    run_seq("cmp", 16'hC050, 1'b1);
    chk("cmp flag_we", 32'(rec_out[2][8]), 32'd1);
    chk("cmp rf_we", 32'(rec_out[4][6]), 32'd0);
    run_seq("st", 16'h4000, 1'b1);
    chk("st mem strobes", 32'(rec_out[3][4:2]), 32'b111);
    chk("st rf_we", 32'(rec_out[4][6]), 32'd0);

    // HLT, resume, then halt again and stop out of HALT
    ph_v = '{1, 2, 3, 6, 6}; rdy_v = '{1, 1, 1, 1, 1};
    run_seq("hlt", 16'hC0F0, 1'b0);
    chk("hlt flag_we", 32'(rec_out[2][8]), 32'd0);
    chk("hlt dr_we", 32'(rec_out[2][9]), 32'd0);
    chk("hlt halted", 32'(rec_out[3][1]), 32'd1);
    chk("hlt retired", 32'(rec_ret[4]), 32'd6);
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    @(negedge clk);
    chk("resume phase", 32'(phase), 32'd1);
    chk("resume retired", 32'(retired), 32'd6);
    stop = 1'b1; wait_idle("hlt"); stop = 1'b0;

    alu_hlt = 1'b1;
    ph_v = '{1, 2, 3, 6, 0}; rdy_v = '{1, 1, 1, 1, 1};
    run_seq("alu hlt", 16'hC000, 1'b1);
    chk("alu hlt dr_we", 32'(rec_out[2][9]), 32'd0);
    chk("alu hlt flag_we", 32'(rec_out[2][8]), 32'd0);
    alu_hlt = 1'b0;

    // Reset while LD waits in P4
    ph_v = '{1, 2, 3, 4}; rdy_v = '{1, 1, 1, 0};
    run_seq("ld abort", 16'h0000, 1'b0);
    mem_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort phase", 32'(phase), 32'd0);
    chk("abort strobes", 32'(outs), 32'd0);
    chk("abort retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Timeout in P1, then ready on the 4th wait cycle
    ph_v = '{1, 1, 1, 1, 7, 7}; rdy_v = '{0, 0, 0, 0, 0, 1};
    run_seq("timeout", 16'hC000, 1'b0);
    chk("timeout err early", 32'(rec_out[3][0]), 32'd0);
    chk("timeout err", 32'(rec_out[4][0]), 32'd1);
    chk("timeout sticky", 32'(rec_out[5][0]), 32'd1);
    pulse_reset();
    ph_v = '{1, 1, 1, 1, 2, 3}; rdy_v = '{0, 0, 0, 1, 0, 0};
    run_seq("late rdy", 16'hC000, 1'b1);
    chk("late rdy ir_we", 32'(rec_out[3][13]), 32'd1);
    wait_idle("late rdy");
    chk("late rdy retired", 32'(retired), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
